reg_bus_arbiter: RTL and testbench
==================================

REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-002 SHALL have parameter REG_ADDR_WIDTH, default 4, register word-address width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  2  per-requester access request; bit i = requester i.
REQ-006 SHALL have port we  input  2  per-requester access type, 1 = write, 0 = read.
REQ-007 SHALL have port addr  input  2*REG_ADDR_WIDTH  per-requester address; requester i in slice i.
REQ-008 SHALL have port wdata  input  2*DATA_WIDTH  per-requester write data.
REQ-009 SHALL have port wstrb  input  2*DATA_WIDTH/8  per-requester byte strobes.
REQ-010 SHALL have port ack  output  2  one-cycle completion pulse to the granted requester.
REQ-011 SHALL have port rdata  output  DATA_WIDTH  shared read data, valid when any ack bit is 1.
REQ-012 SHALL have port err  output  1  shared error flag, valid when any ack bit is 1.
REQ-013 SHALL have port gnt_id  output  1  index of the requester owning the current or last transaction.
REQ-014 SHALL have port reg_addr  output  REG_ADDR_WIDTH  register-file address.
REQ-015 SHALL have port reg_wdata  output  DATA_WIDTH  register-file write data.
REQ-016 SHALL have port reg_wstrb  output  DATA_WIDTH/8  register-file byte strobes.
REQ-017 SHALL have port reg_wen  output  1  register-file write enable.
REQ-018 SHALL have port reg_ren  output  1  register-file read enable.
REQ-019 SHALL have port reg_rdata  input  DATA_WIDTH  register-file read data, valid in the reg_ren cycle.
REQ-020 SHALL have port reg_error  input  1  register-file error, valid in the reg_wen or reg_ren cycle.

Function
REQ-021 SHALL implement FSM states IDLE, ACCESS and RESP, with transitions IDLE->ACCESS when any req bit is 1, ACCESS->RESP unconditionally, and RESP->IDLE unconditionally.
REQ-022 SHALL, in IDLE with any req bit set, select a winner, set gnt_id, and latch that requester's we, addr, wdata and wstrb.
REQ-023 SHALL, in ACCESS, drive reg_addr, reg_wdata and reg_wstrb from the latched values, set reg_wen = latched we and reg_ren = !latched we, and drive both enables 0 in every other state.
REQ-024 SHALL, at the end of ACCESS, capture reg_error into err and capture reg_rdata into rdata for reads; for writes rdata SHALL be captured as 0.
REQ-025 SHALL, in RESP, pulse ack[gnt_id] high for exactly one cycle; rdata and err SHALL hold until the next RESP.
REQ-026 SHALL complete a request asserted in cycle N (FSM in IDLE) with ack in cycle N+2; peak throughput is one access per 3 cycles.
REQ-027 SHALL rely on each requester holding req and its fields stable until ack, and dropping req on the clock edge that samples ack=1.
REQ-028 SHALL ignore req changes while in ACCESS or RESP; a request not granted stays pending and is arbitrated in the next IDLE cycle.
REQ-029 SHALL arbitrate with req[0] winning whenever it is the only request.
REQ-030 SHALL arbitrate with req[1] winning whenever it is the only request.
REQ-031 SHALL resolve simultaneous requests per REQ-036 and REQ-037.
REQ-032 SHALL never assert reg_wen and reg_ren together, and SHALL never assert more than one ack bit.

Reset
REQ-033 SHALL, on rst_n low, asynchronously force FSM=IDLE, ack=0, rdata=0, err=0, gnt_id=1, reg_wen=0, reg_ren=0, reg_addr=0, reg_wdata=0, reg_wstrb=0, and clear all latched fields.
REQ-034 SHALL, on reset during ACCESS or RESP, discard the transaction and produce no ack; requesters SHALL re-issue after reset.
REQ-035 SHALL treat reset deassertion synchronously to the logic: the first arbitration occurs on the first rising edge with rst_n high.

Configuration
REQ-036 SHALL, with macro REG_ARB_ROUND_ROBIN_EN defined, resolve simultaneous requests round-robin: the winner is !gnt_id, and since gnt_id resets to 1, requester 0 wins first after reset.
REQ-037 SHALL, without REG_ARB_ROUND_ROBIN_EN, use fixed priority for simultaneous requests: requester 0 always wins and requester 1 may starve.

Verification
REQ-038 SHALL cover a single write: req=2'b01, we[0]=1, addr[0]=3, wdata[0]=32'hDEADBEEF, wstrb[0]=4'hF -> reg_wen=1 with reg_addr=3 in cycle N+1, then ack=2'b01 and err=0 in cycle N+2.
REQ-039 SHALL cover a single read: req=2'b10, we[1]=0, addr[1]=5, reg_rdata=32'h12345678 -> reg_ren=1 in N+1, then ack=2'b10 with rdata=32'h12345678 in N+2.
REQ-040 SHALL cover contention: req=2'b11 held continuously for 4 transactions -> grant order 0,1,0,1 with REG_ARB_ROUND_ROBIN_EN, and 0,0,0,0 without it.
REQ-041 SHALL cover an error: reg_error=1 during the ACCESS cycle of a write -> err=1 with the ack pulse; the next clean access returns err=0.
REQ-042 SHALL cover reset mid-transaction: rst_n low in ACCESS -> no ack, all outputs at reset values, and a fresh read after release completes in 3 cycles.

Source files
------------

// File: rtl/reg_bus_arbiter_if.sv
// reg_bus_arbiter_if: bundles the two-requester register bus and the
// register-file side of the arbiter into one interface.
//   Requester side : req, we, addr, wdata, wstrb (in to arbiter),
//                    ack, rdata, err, gnt_id (out of arbiter)
//   Register side  : reg_addr, reg_wdata, reg_wstrb, reg_wen, reg_ren
//                    (out of arbiter), reg_rdata, reg_error (in to arbiter)
// Modports: slave  = the arbiter's view,
//           master = the view of whatever drives requests and models the
//                    register file.
interface reg_bus_arbiter_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 4
);
  logic [1:0]                     req;
  logic [1:0]                     we;
  logic [2*REG_ADDR_WIDTH-1:0]    addr;
  logic [2*DATA_WIDTH-1:0]        wdata;
  logic [2*DATA_WIDTH/8-1:0]      wstrb;
  logic [1:0]                     ack;
  logic [DATA_WIDTH-1:0]          rdata;
  logic                           err;
  logic                           gnt_id;
  logic [REG_ADDR_WIDTH-1:0]      reg_addr;
  logic [DATA_WIDTH-1:0]          reg_wdata;
  logic [DATA_WIDTH/8-1:0]        reg_wstrb;
  logic                           reg_wen;
  logic                           reg_ren;
  logic [DATA_WIDTH-1:0]          reg_rdata;
  logic                           reg_error;

  modport slave (
    input  req, we, addr, wdata, wstrb, reg_rdata, reg_error,
    output ack, rdata, err, gnt_id, reg_addr, reg_wdata, reg_wstrb,
           reg_wen, reg_ren
  );

  modport master (
    output req, we, addr, wdata, wstrb, reg_rdata, reg_error,
    input  ack, rdata, err, gnt_id, reg_addr, reg_wdata, reg_wstrb,
           reg_wen, reg_ren
  );
endinterface

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: arbitrates two requesters onto a single register-file
// port. Each access takes IDLE -> ACCESS -> RESP, so a request seen in IDLE
// is acknowledged two cycles later and throughput is one access per three
// cycles.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : reg_bus_arbiter_if.slave (requester and register-file signals)
// Configuration:
//   REG_ARB_ROUND_ROBIN_EN defined   -> simultaneous requests alternate,
//                                       winner is !gnt_id
//   REG_ARB_ROUND_ROBIN_EN undefined -> requester 0 has fixed priority
module reg_bus_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  reg_bus_arbiter_if.slave   bus
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  logic [1:0]                state;
  logic                      lat_we;
  logic                      win;
  logic                      sel_we;
  logic [REG_ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]     sel_wdata;
  logic [STRB_WIDTH-1:0]     sel_wstrb;

  // Winner selection; a lone request always wins regardless of mode.
  always_comb begin
    win = 1'b0;
    if (bus.req == 2'b10) begin
      win = 1'b1;
    end else if (bus.req == 2'b11) begin
`ifdef REG_ARB_ROUND_ROBIN_EN
      win = ~bus.gnt_id;
`else
      win = 1'b0;
`endif
    end
  end

  always_comb begin
    sel_we    = win ? bus.we[1] : bus.we[0];
    sel_addr  = win ? bus.addr[2*REG_ADDR_WIDTH-1:REG_ADDR_WIDTH]
                    : bus.addr[REG_ADDR_WIDTH-1:0];
    sel_wdata = win ? bus.wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                    : bus.wdata[DATA_WIDTH-1:0];
    sel_wstrb = win ? bus.wstrb[2*STRB_WIDTH-1:STRB_WIDTH]
                    : bus.wstrb[STRB_WIDTH-1:0];
  end

  // reg_addr/reg_wdata/reg_wstrb double as the latched request fields: they
  // are loaded on the IDLE->ACCESS edge and simply hold afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      lat_we        <= 1'b0;
      bus.ack       <= 2'b00;
      bus.rdata     <= '0;
      bus.err       <= 1'b0;
      bus.gnt_id    <= 1'b1;
      bus.reg_addr  <= '0;
      bus.reg_wdata <= '0;
      bus.reg_wstrb <= '0;
      bus.reg_wen   <= 1'b0;
      bus.reg_ren   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          bus.ack <= 2'b00;
          if (|bus.req) begin
            state         <= ST_ACCESS;
            bus.gnt_id    <= win;
            lat_we        <= sel_we;
            bus.reg_addr  <= sel_addr;
            bus.reg_wdata <= sel_wdata;
            bus.reg_wstrb <= sel_wstrb;
            bus.reg_wen   <= sel_we;
            bus.reg_ren   <= ~sel_we;
          end
        end
        ST_ACCESS: begin
          state       <= ST_RESP;
          bus.reg_wen <= 1'b0;
          bus.reg_ren <= 1'b0;
          bus.err     <= bus.reg_error;
          bus.rdata   <= lat_we ? '0 : bus.reg_rdata;
          bus.ack     <= bus.gnt_id ? 2'b10 : 2'b01;
        end
        ST_RESP: begin
          state   <= ST_IDLE;
          bus.ack <= 2'b00;
        end
        default: begin
          state       <= ST_IDLE;
          bus.ack     <= 2'b00;
          bus.reg_wen <= 1'b0;
          bus.reg_ren <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
module tb_reg_bus_arbiter;

  logic clk;
  logic rst_n;

  reg_bus_arbiter_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(4)) bus ();

  reg_bus_arbiter #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ack;
    logic [31:0] rdata;
    logic        err;
    logic        gnt;
  } rsp_t;

  typedef struct {
    logic        wen;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } acc_t;

  rsp_t rsp_q[$];
  acc_t acc_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: sampled on the falling edge, away from updates.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.reg_wen || bus.reg_ren) begin
        chk("reg_en_exclusive", {63'b0, bus.reg_wen & bus.reg_ren}, 64'd0);
        if (acc_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_reg_access: wen=%0b ren=%0b", bus.reg_wen, bus.reg_ren);
        end else begin
          acc_t a;
          a = acc_q.pop_front();
          chk("reg_wen", {63'b0, bus.reg_wen}, {63'b0, a.wen});
          chk("reg_ren", {63'b0, bus.reg_ren}, {63'b0, ~a.wen});
          chk("reg_addr", {60'b0, bus.reg_addr}, {60'b0, a.addr});
          if (a.wen) begin
            chk("reg_wdata", {32'b0, bus.reg_wdata}, {32'b0, a.wdata});
            chk("reg_wstrb", {60'b0, bus.reg_wstrb}, {60'b0, a.wstrb});
          end
        end
      end
      if (|bus.ack) begin
        chk("ack_onehot", $countones(bus.ack), 64'd1);
        if (rsp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ack: ack=%0b", bus.ack);
        end else begin
          rsp_t r;
          r = rsp_q.pop_front();
          chk("ack", {62'b0, bus.ack}, {62'b0, r.ack});
          chk("rdata", {32'b0, bus.rdata}, {32'b0, r.rdata});
          chk("err", {63'b0, bus.err}, {63'b0, r.err});
          chk("gnt_id", {63'b0, bus.gnt_id}, {63'b0, r.gnt});
        end
      end
    end
  end

  task automatic push_exp(input int idx, input logic w, input logic [3:0] a,
                          input logic [31:0] wd, input logic [3:0] ws,
                          input logic [31:0] rd, input logic rerr);
    rsp_t r;
    acc_t c;
    r.ack   = (idx == 1) ? 2'b10 : 2'b01;
    r.rdata = w ? 32'h0 : rd;
    r.err   = rerr;
    r.gnt   = (idx == 1);
    rsp_q.push_back(r);
    c.wen   = w;
    c.addr  = a;
    c.wdata = wd;
    c.wstrb = ws;
    acc_q.push_back(c);
  endtask

  task automatic set_fields(input int idx, input logic w, input logic [3:0] a,
                            input logic [31:0] wd, input logic [3:0] ws);
    bus.we[idx]            = w;
    bus.addr[idx*4 +: 4]   = a;
    bus.wdata[idx*32 +: 32] = wd;
    bus.wstrb[idx*4 +: 4]  = ws;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ack"}, {62'b0, bus.ack}, 64'd0);
    chk({tag, "_rdata"}, {32'b0, bus.rdata}, 64'd0);
    chk({tag, "_err"}, {63'b0, bus.err}, 64'd0);
    chk({tag, "_gnt_id"}, {63'b0, bus.gnt_id}, 64'd1);
    chk({tag, "_reg_wen"}, {63'b0, bus.reg_wen}, 64'd0);
    chk({tag, "_reg_ren"}, {63'b0, bus.reg_ren}, 64'd0);
    chk({tag, "_reg_addr"}, {60'b0, bus.reg_addr}, 64'd0);
    chk({tag, "_reg_wdata"}, {32'b0, bus.reg_wdata}, 64'd0);
    chk({tag, "_reg_wstrb"}, {60'b0, bus.reg_wstrb}, 64'd0);
  endtask

  // Single transaction; called just after a rising edge with the FSM idle.
  task automatic single(input int idx, input logic w, input logic [3:0] a,
                        input logic [31:0] wd, input logic [3:0] ws,
                        input logic [31:0] rd, input logic rerr);
    int cycles;
    bit got;
    logic [31:0] exp_rdata;
    exp_rdata = w ? 32'h0 : rd;
    push_exp(idx, w, a, wd, ws, rd, rerr);
    bus.reg_rdata = rd;
    bus.reg_error = rerr;
    set_fields(idx, w, a, wd, ws);
    bus.req[idx] = 1'b1;
    cycles = 0;
    got = 0;
    while (!got && cycles < 10) begin
      @(posedge clk);
      #1;
      cycles++;
      if (|bus.ack) got = 1;
    end
    chk("ack_latency", cycles, 64'd2);
    @(posedge clk);
    #1;
    bus.req[idx] = 1'b0;
    bus.reg_error = 1'b0;
    chk("rdata_hold", {32'b0, bus.rdata}, {32'b0, exp_rdata});
    chk("err_hold", {63'b0, bus.err}, {63'b0, rerr});
    chk("ack_one_cycle", {62'b0, bus.ack}, 64'd0);
  endtask

  task automatic contention();
    int order[4];
    int cycles;
    bit got;
`ifdef REG_ARB_ROUND_ROBIN_EN
    order = '{0, 1, 0, 1};
`else
    order = '{0, 0, 0, 0};
`endif
    bus.reg_rdata = 32'h5555_AAAA;
    bus.reg_error = 1'b0;
    set_fields(0, 1'b1, 4'd1, 32'h1111_0000, 4'h3);
    set_fields(1, 1'b1, 4'd2, 32'h2222_0000, 4'hC);
    for (int i = 0; i < 4; i++) begin
      if (order[i] == 0) push_exp(0, 1'b1, 4'd1, 32'h1111_0000, 4'h3, 32'h0, 1'b0);
      else               push_exp(1, 1'b1, 4'd2, 32'h2222_0000, 4'hC, 32'h0, 1'b0);
    end
    bus.req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      cycles = 0;
      got = 0;
      while (!got && cycles < 10) begin
        @(posedge clk);
        #1;
        cycles++;
        if (|bus.ack) got = 1;
      end
      chk("contention_ack_seen", {63'b0, got}, 64'd1);
      chk("grant_order", {63'b0, bus.gnt_id}, order[i]);
    end
    @(posedge clk);
    #1;
    bus.req = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.req       = 2'b00;
    bus.we        = 2'b00;
    bus.addr      = '0;
    bus.wdata     = '0;
    bus.wstrb     = '0;
    bus.reg_rdata = '0;
    bus.reg_error = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single write from requester 0; reg_rdata is nonzero but must not leak.
    single(0, 1'b1, 4'd3, 32'hDEAD_BEEF, 4'hF, 32'hA5A5_A5A5, 1'b0);
    // Single read from requester 1.
    single(1, 1'b0, 4'd5, 32'h0, 4'h0, 32'h1234_5678, 1'b0);
    // Write with register-file error, then a clean read.
    single(0, 1'b1, 4'd6, 32'h0BAD_0BAD, 4'h5, 32'h0, 1'b1);
    single(1, 1'b0, 4'd8, 32'h0, 4'h0, 32'h8765_4321, 1'b0);

    contention();

    // Reset while in ACCESS.
    bus.reg_rdata = 32'h7777_7777;
    set_fields(0, 1'b0, 4'd7, 32'h0, 4'h0);
    bus.req = 2'b01;
    @(posedge clk);
    #1;
    chk("mid_reg_ren", {63'b0, bus.reg_ren}, 64'd1);
    rst_n = 1'b0;
    bus.req = 2'b00;
    #1;
    check_reset_vals("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    chk("mid_reset_no_ack", {62'b0, bus.ack}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    single(0, 1'b0, 4'd9, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("rsp_q_empty", rsp_q.size(), 64'd0);
    chk("acc_q_empty", acc_q.size(), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
